// File: rtl/counter_n.sv
// WIDTH-bit four-mode counter (up by STEP, down by 1, up by 1, load) with registered Q_, rco_ and load_.
// Define COUNTER_SAT_EN to make the counting modes saturate instead of wrapping.
module counter_n #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_,
    input  logic [1:0]       mode_,
    input  logic [WIDTH-1:0] D_,
    output logic [WIDTH-1:0] Q_,
    output logic             rco_,
    output logic             load_
);

    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH:0]   sum_step_s;
    logic [WIDTH:0]   sum_one_s;
    logic [WIDTH:0]   diff_one_s;
    logic [WIDTH-1:0] q_next_s;
    logic             rco_next_s;
    logic             load_next_s;

    // Extended arithmetic: bit WIDTH is the carry-out for sums and the borrow for the difference.
    always_comb begin
        sum_step_s = {1'b0, Q_} + STEP_EXT;
        sum_one_s  = {1'b0, Q_} + ONE_EXT;
        diff_one_s = {1'b0, Q_} - ONE_EXT;
    end

    // Next-state selection; flags are never held, so a disabled counter clears them.
    always_comb begin
        q_next_s    = Q_;
        rco_next_s  = 1'b0;
        load_next_s = 1'b0;
        if (enable_) begin
            case (mode_)
                2'b00: begin
`ifdef COUNTER_SAT_EN
                    if (sum_step_s[WIDTH]) begin
                        q_next_s   = ALL_ONES;
                        rco_next_s = 1'b1;
                    end else begin
                        q_next_s   = sum_step_s[WIDTH-1:0];
                        rco_next_s = 1'b0;
                    end
`else
                    q_next_s   = sum_step_s[WIDTH-1:0];
                    rco_next_s = sum_step_s[WIDTH];
`endif
                end
                2'b01: begin
`ifdef COUNTER_SAT_EN
                    if (diff_one_s[WIDTH]) begin
                        q_next_s   = ALL_ZERO;
                        rco_next_s = 1'b1;
                    end else begin
                        q_next_s   = diff_one_s[WIDTH-1:0];
                        rco_next_s = 1'b0;
                    end
`else
                    q_next_s   = diff_one_s[WIDTH-1:0];
                    rco_next_s = diff_one_s[WIDTH];
`endif
                end
                2'b10: begin
`ifdef COUNTER_SAT_EN
                    if (sum_one_s[WIDTH]) begin
                        q_next_s   = ALL_ONES;
                        rco_next_s = 1'b1;
                    end else begin
                        q_next_s   = sum_one_s[WIDTH-1:0];
                        rco_next_s = 1'b0;
                    end
`else
                    q_next_s   = sum_one_s[WIDTH-1:0];
                    rco_next_s = sum_one_s[WIDTH];
`endif
                end
                2'b11: begin
                    // A load never reports a wrap, even at the boundary value.
                    q_next_s    = D_;
                    rco_next_s  = 1'b0;
                    load_next_s = 1'b1;
                end
                default: begin
                    q_next_s    = Q_;
                    rco_next_s  = 1'b0;
                    load_next_s = 1'b0;
                end
            endcase
        end else begin
            q_next_s    = Q_;
            rco_next_s  = 1'b0;
            load_next_s = 1'b0;
        end
    end

    // Output registers; synchronous reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q_    <= ALL_ZERO;
            rco_  <= 1'b0;
            load_ <= 1'b0;
        end else begin
            Q_    <= q_next_s;
            rco_  <= rco_next_s;
            load_ <= load_next_s;
        end
    end

endmodule

// File: tb/tb_counter_n.sv
// Directed checks of counter_n (WIDTH=4, STEP=3) plus a random sweep of a WIDTH=8, STEP=5 instance.
// Expectations follow COUNTER_SAT_EN when it is defined for the build.
module tb_counter_n;

    logic       clk = 1'b0;
    logic       reset, enable_;
    logic [1:0] mode_;
    logic [3:0] D_;
    logic [3:0] Q_;
    logic       rco_, load_;

    logic       reset_w, enable_w;
    logic [1:0] mode_w;
    logic [7:0] d_w;
    logic [7:0] q_w;
    logic       rco_w, load_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_n #(.WIDTH(4), .STEP(3)) dut (
        .clk(clk), .reset(reset), .enable_(enable_), .mode_(mode_),
        .D_(D_), .Q_(Q_), .rco_(rco_), .load_(load_)
    );

    counter_n #(.WIDTH(8), .STEP(5)) dut_w (
        .clk(clk), .reset(reset_w), .enable_(enable_w), .mode_(mode_w),
        .D_(d_w), .Q_(q_w), .rco_(rco_w), .load_(load_w)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic en, input logic [1:0] md, input logic [3:0] d);
        reset   = rst;
        enable_ = en;
        mode_   = md;
        D_      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int q, input int r, input int l);
        check_val({tag, ".Q"},    32'(Q_),    32'(q));
        check_val({tag, ".rco"},  32'(rco_),  32'(r));
        check_val({tag, ".load"}, 32'(load_), 32'(l));
    endtask

    int sat;
    int m_q, m_r, m_l, s;

    initial begin
`ifdef COUNTER_SAT_EN
        sat = 1;
`else
        sat = 0;
`endif
        reset_w = 1'b1; enable_w = 1'b0; mode_w = 2'b00; d_w = 8'd0;

        // Reset held for two edges while counting up.
        apply(1'b1, 1'b1, 2'b10, 4'd9);
        apply(1'b1, 1'b1, 2'b10, 4'd9);
        expect3("reset", 0, 0, 0);
        apply(1'b0, 1'b1, 2'b10, 4'd0);
        expect3("first_up", 1, 0, 0);

        // Load 14 then up by STEP across the top.
        apply(1'b0, 1'b1, 2'b11, 4'd14);
        expect3("load14", 14, 0, 1);
        apply(1'b0, 1'b1, 2'b00, 4'd0);
        expect3("step_wrap", sat ? 15 : 1, 1, 0);
        apply(1'b0, 1'b1, 2'b00, 4'd0);
        expect3("step_after", sat ? 15 : 4, sat ? 1 : 0, 0);

        // Down across zero.
        apply(1'b0, 1'b1, 2'b11, 4'd0);
        expect3("load0", 0, 0, 1);
        apply(1'b0, 1'b1, 2'b01, 4'd0);
        expect3("down_borrow", sat ? 0 : 15, 1, 0);
        apply(1'b0, 1'b1, 2'b01, 4'd0);
        expect3("down_after", sat ? 0 : 14, sat ? 1 : 0, 0);

        // Up by one across the top, then hold.
        apply(1'b0, 1'b1, 2'b11, 4'd15);
        expect3("load15", 15, 0, 1);
        apply(1'b0, 1'b1, 2'b10, 4'd0);
        expect3("up_wrap", sat ? 15 : 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 2'b10, 4'd7);
            expect3($sformatf("hold%0d", i), sat ? 15 : 0, 0, 0);
        end
        apply(1'b0, 1'b0, 2'b11, 4'd7);
        expect3("hold_mode11", sat ? 15 : 0, 0, 0);

        // Reset mid-count aborts a pending wrap.
        apply(1'b0, 1'b1, 2'b11, 4'd13);
        expect3("load13", 13, 0, 1);
        apply(1'b1, 1'b1, 2'b00, 4'd0);
        expect3("reset_mid", 0, 0, 0);
        apply(1'b0, 1'b1, 2'b00, 4'd0);
        expect3("after_reset", 3, 0, 0);

        // Mode change takes effect at once; consecutive wraps pulse back to back.
        apply(1'b0, 1'b1, 2'b01, 4'd0);
        expect3("mode_change", 2, 0, 0);
        apply(1'b0, 1'b1, 2'b11, 4'd14);
        apply(1'b0, 1'b1, 2'b10, 4'd0);
        expect3("up_to15", 15, 0, 0);
        apply(1'b0, 1'b1, 2'b00, 4'd0);
        expect3("wrap_a", sat ? 15 : 2, 1, 0);

        // Random sweep of the wide instance against an arithmetic model.
        reset = 1'b1; enable_ = 1'b0;
        reset_w = 1'b1;
        @(posedge clk); #1;
        m_q = 0;
        check_val("w_reset.Q", 32'(q_w), 32'd0);
        for (int i = 0; i < 1000; i++) begin
            reset_w  = ($urandom_range(0, 31) == 0);
            enable_w = ($urandom_range(0, 3) != 0);
            mode_w   = 2'($urandom_range(0, 3));
            d_w      = 8'($urandom_range(0, 255));
            if (i % 97 == 5) begin
                mode_w = 2'b11; d_w = (i % 2 == 1) ? 8'd255 : 8'd0;
            end
            m_r = 0; m_l = 0;
            if (reset_w) begin
                m_q = 0;
            end else if (enable_w) begin
                case (mode_w)
                    2'b00: begin
                        s = m_q + 5;
                        if (s > 255) begin m_r = 1; m_q = sat ? 255 : s - 256; end
                        else m_q = s;
                    end
                    2'b01: begin
                        if (m_q == 0) begin m_r = 1; m_q = sat ? 0 : 255; end
                        else m_q = m_q - 1;
                    end
                    2'b10: begin
                        if (m_q == 255) begin m_r = 1; m_q = sat ? 255 : 0; end
                        else m_q = m_q + 1;
                    end
                    default: begin m_q = int'(d_w); m_l = 1; end
                endcase
            end
            @(posedge clk); #1;
            check_val($sformatf("w%0d.Q", i),    32'(q_w),    32'(m_q));
            check_val($sformatf("w%0d.rco", i),  32'(rco_w),  32'(m_r));
            check_val($sformatf("w%0d.load", i), 32'(load_w), 32'(m_l));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
